servo_slew_pwm: RTL and testbench
=================================

// Module: servo_slew_pwm
// PURPOSE
//  Downstream servo driver for the arm sequencer: one instance per joint (claw, upper, lower).
//  Takes a commanded position (DESIRED) and ramps an internal position toward it at a fixed rate.
//  Produces a frame-synchronous servo PWM from that position.
//  Raises FLAG once the joint has settled on target; the sequencer gates its state advance on FLAG.
// PARAMETERS
//  FRAME_LEN     2000000  PWM frame length in CLK cycles (20 ms @ 100 MHz); must be < 2^21
//  PULSE_MIN     50000    pulse width at position 0 (0.5 ms)
//  POS_MAX       200000   max position; PULSE_MIN+POS_MAX < FRAME_LEN required
//  INIT_POS      100000   position loaded at reset (must be <= POS_MAX)
//  STEP          64       position increment per slew tick
//  STEP_DIV      256      CLK cycles per slew tick (>= 1)
//  SETTLE_FRAMES 3        consecutive frame starts on target before FLAG rises (>= 1)
// PORTS
//  CLK          in   1   system clock, 100 MHz
//  RST_N        in   1   reset; one clock, asynchronous, active-low
//  ENABLE       in   1   1 = drive pulses and slew; 0 = PWM held low, position frozen
//  DESIRED      in   20  commanded position, unsigned; values > POS_MAX are clamped
//  PWM          out  1   servo pulse output, registered
//  FLAG         out  1   1 = position == target and settled for SETTLE_FRAMES frames
//  POSITION     out  20  current ramped position
//  FRAME_START  out  1   one-cycle pulse when the frame counter is 0
// BEHAVIOUR
//  Reset (RST_N low, async):
//   - POSITION=INIT_POS, PWM=0, FLAG=0, FRAME_START=0.
//   - Frame counter, slew prescaler, settle counter = 0; state=HOLD.
//   - First cycle after release: frame counter=0, so FRAME_START=1.
//  Target register:
//   - tgt <= min(DESIRED, POS_MAX) every cycle while ENABLE=1.
//   - One cycle of latency from DESIRED to tgt.
//  Frame counter:
//   - Counts 0..FRAME_LEN-1 and wraps to 0. Runs regardless of ENABLE.
//   - FRAME_START = (cnt==0), registered alongside cnt.
//  Pulse latch:
//   - At cnt==0: width <= PULSE_MIN + POSITION (21-bit) and en_l <= ENABLE.
//   - PWM <= en_l && (cnt < width).
//   - Mid-frame changes to DESIRED, POSITION or ENABLE never alter the current frame (no runt or stretched pulses).
//  Slew prescaler:
//   - Counts 0..STEP_DIV-1 while ENABLE=1; tick when it reaches STEP_DIV-1.
//   - Held at 0 while ENABLE=0.
//  FSM:
//   - HOLD: POSITION==tgt. Go to SLEW the cycle after tgt != POSITION.
//   - SLEW: on each tick, move toward tgt by STEP, never overshooting:
//       pos < tgt -> pos = min(pos+STEP, tgt)
//       pos > tgt -> pos = max(pos-STEP, tgt)
//     Go to HOLD when POSITION==tgt.
//   - Target reversal during SLEW: simply ramp the other way; no pause, no reset of the prescaler.
//  Arithmetic:
//   - Done at 21 bits, so pos+STEP cannot wrap.
//   - pos-STEP is guarded by comparison before subtraction, so it cannot underflow.
//  FLAG:
//   - Settle counter increments at each FRAME_START while in HOLD with ENABLE=1, saturating at SETTLE_FRAMES.
//   - FLAG=1 when settle counter == SETTLE_FRAMES.
//   - Any cycle with tgt != POSITION, or ENABLE=0: settle counter <= 0 and FLAG <= 0 on the next edge.
//  Simultaneous events:
//   - Tick and target change in the same cycle: the step uses the old tgt.
//   - FRAME_START and tick in the same cycle: the pulse latches the pre-step POSITION.
//  Reset mid-slew or mid-pulse: PWM drops immediately (async); POSITION returns to INIT_POS.
// TESTING (bench params: FRAME_LEN=1000 PULSE_MIN=100 POS_MAX=500 INIT_POS=250 STEP=7 STEP_DIV=4 SETTLE_FRAMES=2)
//  1. Reset: hold RST_N=0 -> PWM=0, FLAG=0, POSITION=250. Release -> FRAME_START on first cycle, then every 1000 cycles.
//  2. Hold: ENABLE=1, DESIRED=250 -> PWM high exactly 350 cycles per frame; FLAG=1 after the 2nd FRAME_START.
//  3. Slew up: DESIRED 250->300 -> FLAG=0 next cycle; POSITION 257,264,...,299,300, one step every 4 cycles; FLAG=1 two frames after reaching 300.
//  4. Clamp and slew down: DESIRED=900 -> POSITION stops at 500, pulse=600. Then DESIRED=0 -> ramps to 0, pulse=100.
//  5. Mid-frame: change DESIRED or drop ENABLE at cnt=50 -> current pulse width unchanged; the next frame reflects the change (ENABLE=0 -> PWM=0).
//  6. Async reset asserted mid-pulse during a slew -> PWM=0 within the same cycle; POSITION=250, FLAG=0.

Source files
------------

// File: rtl/servo_slew_pwm_if.sv
// Purpose : command/status bundle between the arm sequencer and one servo joint driver.
// Latency : n/a (wires only).
// Flow    : no backpressure; desired/enable are level commands, status is continuous.
// Ports   : enable, desired[19:0] (sequencer -> driver); pwm, flag, position[19:0], frame_start (driver -> sequencer).
interface servo_slew_pwm_if;
  logic        enable;
  logic [19:0] desired;
  logic        pwm;
  logic        flag;
  logic [19:0] position;
  logic        frame_start;

  modport master (
    output enable, desired,
    input  pwm, flag, position, frame_start
  );

  modport slave (
    input  enable, desired,
    output pwm, flag, position, frame_start
  );
endinterface

// File: rtl/servo_slew_pwm.sv
// Purpose : per-joint servo driver; ramps position toward the commanded target and emits a frame-locked PWM.
// Latency : desired -> target 1 cycle; target -> first step 1..STEP_DIV+1 cycles; pulse width latched at frame start.
// Flow    : no backpressure; flag high once the joint has sat on target for SETTLE_FRAMES frame starts.
// Ports   : clk_i, rst_ni (async, active-low); srv (slave modport): enable, desired in; pwm, flag, position, frame_start out.
module servo_slew_pwm #(
  parameter int unsigned FRAME_LEN     = 2000000,
  parameter int unsigned PULSE_MIN     = 50000,
  parameter int unsigned POS_MAX       = 200000,
  parameter int unsigned INIT_POS      = 100000,
  parameter int unsigned STEP          = 64,
  parameter int unsigned STEP_DIV      = 256,
  parameter int unsigned SETTLE_FRAMES = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  servo_slew_pwm_if.slave   srv
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SW = $clog2(SETTLE_FRAMES + 1);

  localparam logic [19:0]   POS_MAX_W    = 20'(POS_MAX);
  localparam logic [19:0]   INIT_POS_W   = 20'(INIT_POS);
  localparam logic [20:0]   STEP_W       = 21'(STEP);
  localparam logic [20:0]   PULSE_MIN_W  = 21'(PULSE_MIN);
  localparam logic [20:0]   FRAME_LAST   = 21'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SETTLE_W     = SW'(SETTLE_FRAMES);

  typedef enum logic {HOLD, SLEW} state_e;

  state_e        state_q, state_d;
  logic [19:0]   tgt_q, tgt_d;
  logic [19:0]   pos_q, pos_d;
  logic [20:0]   cnt_q, cnt_d;
  logic          frame_start_q, frame_start_d;
  logic [20:0]   width_q, width_d;
  logic          en_l_q, en_l_d;
  logic          pwm_q, pwm_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          flag_q, flag_d;

  logic          tick;
  logic [20:0]   pos_ext;
  logic [20:0]   tgt_ext;
  logic [20:0]   step_pos;

  always_comb begin
    tgt_d         = tgt_q;
    presc_d       = '0;
    state_d       = state_q;
    step_pos      = {1'b0, pos_q};
    pos_ext       = {1'b0, pos_q};
    tgt_ext       = {1'b0, tgt_q};
    cnt_d         = (cnt_q == FRAME_LAST) ? '0 : cnt_q + 21'd1;
    frame_start_d = (cnt_q == '0);
    width_d       = width_q;
    en_l_d        = en_l_q;
    settle_d      = settle_q;

    if (srv.enable) begin
      tgt_d = (srv.desired > POS_MAX_W) ? POS_MAX_W : srv.desired;
    end

    // Prescaler only advances while enabled, so a disabled joint freezes in place.
    tick = srv.enable && (presc_q == PRESC_LAST);
    if (srv.enable && !tick) begin
      presc_d = presc_q + 1'b1;
    end

    case (state_q)
      HOLD: begin
        if (tgt_q != pos_q) state_d = SLEW;
      end
      default: begin
        // Steps compare against the registered target, so a same-cycle target change waits one cycle.
        if (tick) begin
          if (pos_ext < tgt_ext) begin
            step_pos = (pos_ext + STEP_W > tgt_ext) ? tgt_ext : pos_ext + STEP_W;
          end else if (pos_ext > tgt_ext) begin
            step_pos = (pos_ext >= tgt_ext + STEP_W) ? pos_ext - STEP_W : tgt_ext;
          end
        end
        if (pos_q == tgt_q) state_d = HOLD;
      end
    endcase
    pos_d = step_pos[19:0];

    // Width and enable are frozen for the whole frame; the latch sees the pre-step position.
    if (cnt_q == '0) begin
      width_d = PULSE_MIN_W + pos_ext;
      en_l_d  = srv.enable;
    end
    pwm_d = en_l_d && (cnt_q < width_d);

    if ((tgt_q != pos_q) || !srv.enable) begin
      settle_d = '0;
    end else if (frame_start_q && (state_q == HOLD) && (settle_q != SETTLE_W)) begin
      settle_d = settle_q + 1'b1;
    end
    flag_d = (settle_d == SETTLE_W);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= HOLD;
      tgt_q         <= INIT_POS_W;
      pos_q         <= INIT_POS_W;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      width_q       <= '0;
      en_l_q        <= 1'b0;
      pwm_q         <= 1'b0;
      presc_q       <= '0;
      settle_q      <= '0;
      flag_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      width_q       <= width_d;
      en_l_q        <= en_l_d;
      pwm_q         <= pwm_d;
      presc_q       <= presc_d;
      settle_q      <= settle_d;
      flag_q        <= flag_d;
    end
  end

  assign srv.pwm         = pwm_q;
  assign srv.flag        = flag_q;
  assign srv.position    = pos_q;
  assign srv.frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_slew_pwm.sv
// Purpose : scoreboard bench for servo_slew_pwm with a cycle reference model and directed + random commands.
// Latency : model predicts each cycle's outputs at the clock edge; monitor compares on the falling edge.
// Flow    : no backpressure; all waits are bounded by cycle budgets.
module tb_servo_slew_pwm;

  localparam int FL   = 1000;
  localparam int PMIN = 100;
  localparam int PMAX = 500;
  localparam int IPOS = 250;
  localparam int STP  = 7;
  localparam int SDIV = 4;
  localparam int SETF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  servo_slew_pwm_if sif();

  servo_slew_pwm #(
    .FRAME_LEN(FL), .PULSE_MIN(PMIN), .POS_MAX(PMAX), .INIT_POS(IPOS),
    .STEP(STP), .STEP_DIV(SDIV), .SETTLE_FRAMES(SETF)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .srv   (sif.slave)
  );

  typedef struct {
    int pwm;
    int flag;
    int pos;
    int fs;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain integers describing the joint's behaviour.
  int m_tgt, m_pos, m_cnt, m_width, m_presc, m_settle;
  bit m_moving, m_fs, m_enl, m_pwm, m_flag;
  int n_tgt, n_pos, n_width, n_presc, n_settle;
  bit n_tick, n_enl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tgt = IPOS; m_pos = IPOS; m_cnt = 0; m_width = 0; m_presc = 0; m_settle = 0;
      m_moving = 0; m_fs = 0; m_enl = 0; m_pwm = 0; m_flag = 0;
      expq.delete();
      expq.push_back('{0, 0, IPOS, 0});
    end else begin
      n_tick  = sif.enable && (m_presc == SDIV - 1);
      n_presc = (sif.enable && !n_tick) ? m_presc + 1 : 0;
      n_tgt   = sif.enable ? ((int'(sif.desired) > PMAX) ? PMAX : int'(sif.desired)) : m_tgt;
      n_pos   = m_pos;
      if (m_moving && n_tick) begin
        if (m_pos < m_tgt)      n_pos = (m_pos + STP < m_tgt) ? m_pos + STP : m_tgt;
        else if (m_pos > m_tgt) n_pos = (m_pos - STP > m_tgt) ? m_pos - STP : m_tgt;
      end
      n_width = (m_cnt == 0) ? PMIN + m_pos : m_width;
      n_enl   = (m_cnt == 0) ? sif.enable : m_enl;
      if (m_tgt != m_pos || !sif.enable) n_settle = 0;
      else if (m_fs && !m_moving)        n_settle = (m_settle < SETF) ? m_settle + 1 : SETF;
      else                               n_settle = m_settle;

      m_pwm    = n_enl && (m_cnt < n_width);
      m_fs     = (m_cnt == 0);
      m_cnt    = (m_cnt == FL - 1) ? 0 : m_cnt + 1;
      m_moving = (m_tgt != m_pos);
      m_tgt    = n_tgt;
      m_pos    = n_pos;
      m_width  = n_width;
      m_enl    = n_enl;
      m_presc  = n_presc;
      m_settle = n_settle;
      m_flag   = (n_settle == SETF);
      expq.push_back('{int'(m_pwm), int'(m_flag), m_pos, int'(m_fs)});
    end
  end

  // Monitor: pops one expectation per cycle, also measures pulse widths and logs position changes.
  exp_t e;
  int   hi = 0;
  int   last_width = -1;
  bit   log_en = 0;
  int   prev_pos = 0;
  int   pos_log[$];

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_checks++;
      if (sif.pwm !== 1'(e.pwm) || sif.flag !== 1'(e.flag) ||
          sif.position !== 20'(e.pos) || sif.frame_start !== 1'(e.fs)) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got pwm=%b flag=%b pos=%0d fs=%b, expected pwm=%0d flag=%0d pos=%0d fs=%0d",
                 $time, sif.pwm, sif.flag, sif.position, sif.frame_start, e.pwm, e.flag, e.pos, e.fs);
      end
    end
    if (sif.frame_start === 1'b1) begin
      last_width = hi;
      hi = (sif.pwm === 1'b1) ? 1 : 0;
    end else if (sif.pwm === 1'b1) begin
      hi++;
    end
    if (log_en && int'(sif.position) != prev_pos) pos_log.push_back(int'(sif.position));
    prev_pos = int'(sif.position);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_fs(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (sif.frame_start !== 1'b1 && cycles < 2 * FL);
    if (sif.frame_start !== 1'b1) check("frame_start_timeout", 0, 1);
    #1;
  endtask

  int n;
  int exp_seq[$];
  int p;

  initial begin
    sif.enable  = 1'b1;
    sif.desired = 20'd250;
    rst_n       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_pwm", int'(sif.pwm), 0);
    check("reset_flag", int'(sif.flag), 0);
    check("reset_pos", int'(sif.position), IPOS);
    check("reset_fs", int'(sif.frame_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sif.frame_start !== 1'b1 && n < 10);
    #1;
    check("first_fs_cycle", n, 1);
    wait_fs(n);
    check("frame_period", n, FL);

    // Hold on target
    wait_fs(n);
    check("hold_width", last_width, PMIN + 250);
    check("hold_flag", int'(sif.flag), 1);

    // Slew up 250 -> 300
    pos_log.delete();
    prev_pos = int'(sif.position);
    log_en = 1'b1;
    sif.desired = 20'd300;
    repeat (3) @(negedge clk);
    #1;
    check("slew_flag_drop", int'(sif.flag), 0);
    wait_fs(n);
    wait_fs(n);
    log_en = 1'b0;
    check("slew_width", last_width, PMIN + 300);
    p = 250;
    exp_seq.delete();
    while (p < 300) begin
      p = (p + STP < 300) ? p + STP : 300;
      exp_seq.push_back(p);
    end
    check("slew_seq_len", pos_log.size(), exp_seq.size());
    foreach (exp_seq[i]) begin
      if (i < pos_log.size()) check($sformatf("slew_seq[%0d]", i), pos_log[i], exp_seq[i]);
    end
    @(negedge clk);
    #1;
    check("slew_flag_settled", int'(sif.flag), 1);

    // Clamp high, then ramp to zero
    sif.desired = 20'd900;
    wait_fs(n);
    wait_fs(n);
    check("clamp_pos", int'(sif.position), PMAX);
    check("clamp_width", last_width, PMIN + PMAX);
    sif.desired = 20'd0;
    wait_fs(n);
    wait_fs(n);
    check("zero_pos", int'(sif.position), 0);
    check("zero_width", last_width, PMIN);

    // Mid-frame changes do not disturb the current pulse
    repeat (48) @(negedge clk);
    sif.desired = 20'd300;
    wait_fs(n);
    check("midframe_cur_width", last_width, PMIN);
    wait_fs(n);
    check("midframe_next_width", last_width, PMIN + 300);
    repeat (48) @(negedge clk);
    sif.enable = 1'b0;
    wait_fs(n);
    check("disable_cur_width", last_width, PMIN + 300);
    wait_fs(n);
    check("disable_next_width", last_width, 0);
    sif.enable = 1'b1;

    // Random commands, enable mostly on
    for (int k = 0; k < 20; k++) begin
      sif.desired = 20'($urandom_range(0, 700));
      sif.enable  = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 1500)) @(negedge clk);
    end
    sif.enable = 1'b1;

    // Async reset mid-pulse during a slew
    sif.desired = 20'd0;
    repeat (400) @(negedge clk);
    sif.desired = 20'd500;
    wait_fs(n);
    repeat (20) @(negedge clk);
    #1;
    check("pre_reset_pwm", int'(sif.pwm), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pwm", int'(sif.pwm), 0);
    check("async_pos", int'(sif.position), IPOS);
    check("async_flag", int'(sif.flag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
